// File: rtl/sc_statemachine_pkg.sv
// Shared state codes and width helper for the Frogger game controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sc_statemachine_pkg;

  // 4-bit state codes, also driven on the debug state bus
  localparam logic [3:0] ST_RESET    = 4'd0;
  localparam logic [3:0] ST_START    = 4'd1;
  localparam logic [3:0] ST_LOAD     = 4'd2;
  localparam logic [3:0] ST_PLAY     = 4'd3;
  localparam logic [3:0] ST_DIE      = 4'd4;
  localparam logic [3:0] ST_LEVELUP  = 4'd5;
  localparam logic [3:0] ST_GAMEOVER = 4'd6;
  localparam logic [3:0] ST_WIN      = 4'd7;

  // Bits needed to hold 0..v-1, never less than one bit
  function automatic int width_min1(input int v);
    if (v <= 1) return 1;
    return $clog2(v);
  endfunction

endpackage

// File: rtl/sc_edge_detect_falling.sv
// Falling-edge detector: one-cycle pulse when the input goes 1 -> 0.
// Latency: pulse is combinational in the cycle the low level is first seen.
// Backpressure: none; a held-low input yields exactly one pulse.
module sc_edge_detect_falling (
  input  logic SC_EDGEDETECTFALLING_CLOCK_50,
  input  logic SC_EDGEDETECTFALLING_RESET_InLow,
  input  logic SC_EDGEDETECTFALLING_signal_In,
  output logic SC_EDGEDETECTFALLING_fall_OutHigh
);

  logic prev_q;

  // History register; resets high so a button held through reset is not an edge
  always_ff @(posedge SC_EDGEDETECTFALLING_CLOCK_50 or negedge SC_EDGEDETECTFALLING_RESET_InLow) begin
    if (!SC_EDGEDETECTFALLING_RESET_InLow) prev_q <= 1'b1;
    else                                   prev_q <= SC_EDGEDETECTFALLING_signal_In;
  end

  assign SC_EDGEDETECTFALLING_fall_OutHigh = prev_q & ~SC_EDGEDETECTFALLING_signal_In;

endmodule

// File: rtl/sc_statemachine_levels.sv
// Frogger game controller: start, level load, play, die, level-up, game over, win.
// Latency: Moore outputs; collision/goal to play=0 is one clock.
// Backpressure: none; collision/goal only sampled in PLAY, start only in START/GAMEOVER/WIN.
module sc_statemachine_levels
  import sc_statemachine_pkg::*;
#(
  parameter int NUM_LEVELS   = 4,
  parameter int NUM_LIVES    = 3,
  parameter int PAUSE_CYCLES = 50000000,
  parameter int LEVEL_W      = width_min1(NUM_LEVELS),
  parameter int LIVES_W      = width_min1(NUM_LIVES + 1)
) (
  input  logic               SC_STATEMACHINELEVELS_CLOCK_50,
  input  logic               SC_STATEMACHINELEVELS_RESET_InLow,
  input  logic               SC_STATEMACHINELEVELS_startButton_InLow,
  input  logic               SC_STATEMACHINELEVELS_collision_InHigh,
  input  logic               SC_STATEMACHINELEVELS_goal_InHigh,
  output logic               SC_STATEMACHINELEVELS_clear_OutLow,
  output logic               SC_STATEMACHINELEVELS_load_OutHigh,
  output logic               SC_STATEMACHINELEVELS_play_OutHigh,
  output logic [LEVEL_W-1:0] SC_STATEMACHINELEVELS_level_Out,
  output logic [LIVES_W-1:0] SC_STATEMACHINELEVELS_lives_Out,
  output logic               SC_STATEMACHINELEVELS_gameOver_OutHigh,
  output logic               SC_STATEMACHINELEVELS_win_OutHigh,
  output logic [3:0]         SC_STATEMACHINELEVELS_state_Out
);

  localparam int PAUSE_W = width_min1(PAUSE_CYCLES + 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

  typedef enum logic [3:0] {
    S_RESET    = ST_RESET,
    S_START    = ST_START,
    S_LOAD     = ST_LOAD,
    S_PLAY     = ST_PLAY,
    S_DIE      = ST_DIE,
    S_LEVELUP  = ST_LEVELUP,
    S_GAMEOVER = ST_GAMEOVER,
    S_WIN      = ST_WIN
  } state_t;

  state_t               state_q, state_d;
  logic [LEVEL_W-1:0]   level_q;
  logic [LIVES_W-1:0]   lives_q;
  logic [PAUSE_W-1:0]   pause_q;
  logic                 start_evt;
  logic                 pause_done;
  logic                 in_pause;
  logic                 to_pause;

  sc_edge_detect_falling u_start_edge (
    .SC_EDGEDETECTFALLING_CLOCK_50    (SC_STATEMACHINELEVELS_CLOCK_50),
    .SC_EDGEDETECTFALLING_RESET_InLow (SC_STATEMACHINELEVELS_RESET_InLow),
    .SC_EDGEDETECTFALLING_signal_In   (SC_STATEMACHINELEVELS_startButton_InLow),
    .SC_EDGEDETECTFALLING_fall_OutHigh(start_evt)
  );

  assign in_pause   = (state_q == S_DIE) || (state_q == S_LEVELUP);
  assign to_pause   = (state_d == S_DIE) || (state_d == S_LEVELUP);
  assign pause_done = (pause_q == PAUSE_W'(PAUSE_CYCLES));

  // Next-state decode; collision has priority over goal in PLAY
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:    state_d = S_START;
      S_START:    if (start_evt) state_d = S_LOAD;
      S_LOAD:     state_d = S_PLAY;
      S_PLAY: begin
        if (SC_STATEMACHINELEVELS_collision_InHigh)                          state_d = S_DIE;
        else if (SC_STATEMACHINELEVELS_goal_InHigh && level_q == LAST_LEVEL) state_d = S_WIN;
        else if (SC_STATEMACHINELEVELS_goal_InHigh)                          state_d = S_LEVELUP;
      end
      S_DIE:      if (pause_done) state_d = (lives_q == '0) ? S_GAMEOVER : S_LOAD;
      S_LEVELUP:  if (pause_done) state_d = S_LOAD;
      S_GAMEOVER: if (start_evt) state_d = S_RESET;
      S_WIN:      if (start_evt) state_d = S_RESET;
      default:    state_d = S_RESET;
    endcase
  end

  // State register
  always_ff @(posedge SC_STATEMACHINELEVELS_CLOCK_50 or negedge SC_STATEMACHINELEVELS_RESET_InLow) begin
    if (!SC_STATEMACHINELEVELS_RESET_InLow) state_q <= S_RESET;
    else                                    state_q <= state_d;
  end

  // Level/lives counters and the pause timer (1..PAUSE_CYCLES while paused)
  always_ff @(posedge SC_STATEMACHINELEVELS_CLOCK_50 or negedge SC_STATEMACHINELEVELS_RESET_InLow) begin
    if (!SC_STATEMACHINELEVELS_RESET_InLow) begin
      level_q <= '0;
      lives_q <= LIVES_W'(NUM_LIVES);
      pause_q <= '0;
    end else begin
      // Reinitialise on entry to RESET as well, so a restart shows fresh counters at once
      if (state_q == S_RESET || state_d == S_RESET) begin
        level_q <= '0;
        lives_q <= LIVES_W'(NUM_LIVES);
      end else if (state_q == S_PLAY) begin
        if (SC_STATEMACHINELEVELS_collision_InHigh) begin
          if (lives_q != '0) lives_q <= lives_q - LIVES_W'(1);
        end else if (SC_STATEMACHINELEVELS_goal_InHigh && level_q != LAST_LEVEL) begin
          level_q <= level_q + LEVEL_W'(1);
        end
      end
      if (to_pause) pause_q <= in_pause ? pause_q + PAUSE_W'(1) : PAUSE_W'(1);
      else          pause_q <= '0;
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    SC_STATEMACHINELEVELS_clear_OutLow     = 1'b1;
    SC_STATEMACHINELEVELS_load_OutHigh     = 1'b0;
    SC_STATEMACHINELEVELS_play_OutHigh     = 1'b0;
    SC_STATEMACHINELEVELS_gameOver_OutHigh = 1'b0;
    SC_STATEMACHINELEVELS_win_OutHigh      = 1'b0;
    case (state_q)
      S_RESET:    SC_STATEMACHINELEVELS_clear_OutLow = 1'b0;
      S_LOAD: begin
        SC_STATEMACHINELEVELS_clear_OutLow = 1'b0;
        SC_STATEMACHINELEVELS_load_OutHigh = 1'b1;
      end
      S_PLAY:     SC_STATEMACHINELEVELS_play_OutHigh     = 1'b1;
      S_GAMEOVER: SC_STATEMACHINELEVELS_gameOver_OutHigh = 1'b1;
      S_WIN:      SC_STATEMACHINELEVELS_win_OutHigh      = 1'b1;
      default:    ;
    endcase
  end

  assign SC_STATEMACHINELEVELS_level_Out = level_q;
  assign SC_STATEMACHINELEVELS_lives_Out = lives_q;
  assign SC_STATEMACHINELEVELS_state_Out = state_q;

endmodule

// File: tb/tb_sc_statemachine_levels.sv
// Directed bench for the Frogger game controller (3 levels, 3 lives, pause 4).
// Latency: each vector drives inputs for one clock and checks outputs after the edge.
// Backpressure: not applicable.
module tb_sc_statemachine_levels;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n, coll, goal;
  logic       clear_n, load, play, game_over, win;
  logic [1:0] level, lives;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sc_statemachine_levels #(
    .NUM_LEVELS  (3),
    .NUM_LIVES   (3),
    .PAUSE_CYCLES(4)
  ) dut (
    .SC_STATEMACHINELEVELS_CLOCK_50         (clk),
    .SC_STATEMACHINELEVELS_RESET_InLow      (rst_n),
    .SC_STATEMACHINELEVELS_startButton_InLow(start_n),
    .SC_STATEMACHINELEVELS_collision_InHigh (coll),
    .SC_STATEMACHINELEVELS_goal_InHigh      (goal),
    .SC_STATEMACHINELEVELS_clear_OutLow     (clear_n),
    .SC_STATEMACHINELEVELS_load_OutHigh     (load),
    .SC_STATEMACHINELEVELS_play_OutHigh     (play),
    .SC_STATEMACHINELEVELS_level_Out        (level),
    .SC_STATEMACHINELEVELS_lives_Out        (lives),
    .SC_STATEMACHINELEVELS_gameOver_OutHigh (game_over),
    .SC_STATEMACHINELEVELS_win_OutHigh      (win),
    .SC_STATEMACHINELEVELS_state_Out        (state)
  );

  typedef struct {
    logic       s, c, g;
    logic [3:0] st;
    logic       clr, ld, pl;
    logic [1:0] lvl, liv;
    logic       go, wn;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic s, c, g, input logic [3:0] st,
                              input logic clr, ld, pl, input logic [1:0] lvl, liv,
                              input logic go, wn);
    vec_t v;
    v.s = s; v.c = c; v.g = g; v.st = st;
    v.clr = clr; v.ld = ld; v.pl = pl;
    v.lvl = lvl; v.liv = liv; v.go = go; v.wn = wn;
    vq.push_back(v);
  endfunction

  // Observed outputs packed as {state, clear, load, play, level, lives, gameOver, win}
  function automatic logic [12:0] observed();
    return {state, clear_n, load, play, level, lives, game_over, win};
  endfunction

  task automatic check(input string name, input logic [3:0] st, input logic clr, ld, pl,
                       input logic [1:0] lvl, liv, input logic go, wn);
    logic [12:0] exp_v;
    logic [12:0] act_v;
    exp_v = {st, clr, ld, pl, lvl, liv, go, wn};
    act_v = observed();
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got st=%0d clr=%b ld=%b pl=%b lvl=%0d liv=%0d go=%b win=%b, want st=%0d clr=%b ld=%b pl=%b lvl=%0d liv=%0d go=%b win=%b",
               name, act_v[12:9], act_v[8], act_v[7], act_v[6], act_v[5:4], act_v[3:2], act_v[1], act_v[0],
               st, clr, ld, pl, lvl, liv, go, wn);
    end
  endtask

  // Drive one cycle of inputs, then let the edge land and settle
  task automatic step(input logic s, c, g);
    start_n = s; coll = c; goal = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start_n = 1'b1; coll = 1'b0; goal = 1'b0;

    //    s c g  st clr ld pl lvl liv go wn
    add(1,0,0, 1, 1,0,0, 0,3, 0,0);               // RESET -> START
    add(0,0,0, 2, 0,1,0, 0,3, 0,0);               // press: one LOAD cycle
    add(0,0,0, 3, 1,0,1, 0,3, 0,0);               // PLAY
    for (int i = 0; i < 8; i++)
      add(0,0,0, 3, 1,0,1, 0,3, 0,0);             // held button: no further load
    add(1,1,0, 4, 1,0,0, 0,2, 0,0);               // collision -> DIE, lives 2
    add(1,1,1, 4, 1,0,0, 0,2, 0,0);               // flags ignored in DIE
    add(1,0,0, 4, 1,0,0, 0,2, 0,0);
    add(1,0,0, 4, 1,0,0, 0,2, 0,0);               // 4th DIE cycle
    add(1,0,0, 2, 0,1,0, 0,2, 0,0);               // reload
    add(1,0,0, 3, 1,0,1, 0,2, 0,0);
    add(1,1,1, 4, 1,0,0, 0,1, 0,0);               // collision beats goal
    for (int i = 0; i < 3; i++)
      add(1,0,0, 4, 1,0,0, 0,1, 0,0);
    add(1,0,0, 2, 0,1,0, 0,1, 0,0);
    add(1,0,0, 3, 1,0,1, 0,1, 0,0);
    add(1,1,0, 4, 1,0,0, 0,0, 0,0);               // last life lost
    for (int i = 0; i < 3; i++)
      add(1,0,0, 4, 1,0,0, 0,0, 0,0);
    add(1,0,0, 6, 1,0,0, 0,0, 1,0);               // GAMEOVER
    add(1,1,1, 6, 1,0,0, 0,0, 1,0);               // holds, flags ignored
    add(0,0,0, 0, 0,0,0, 0,3, 0,0);               // start -> RESET, counters fresh
    add(0,0,0, 1, 1,0,0, 0,3, 0,0);               // START, held button no event
    add(0,0,0, 1, 1,0,0, 0,3, 0,0);
    add(1,0,0, 1, 1,0,0, 0,3, 0,0);
    add(0,0,0, 2, 0,1,0, 0,3, 0,0);
    add(1,0,0, 3, 1,0,1, 0,3, 0,0);
    add(1,0,1, 5, 1,0,0, 1,3, 0,0);               // goal on level 0
    for (int i = 0; i < 3; i++)
      add(1,0,0, 5, 1,0,0, 1,3, 0,0);
    add(1,0,0, 2, 0,1,0, 1,3, 0,0);
    add(1,0,0, 3, 1,0,1, 1,3, 0,0);
    add(1,0,1, 5, 1,0,0, 2,3, 0,0);               // goal on level 1
    for (int i = 0; i < 3; i++)
      add(1,0,0, 5, 1,0,0, 2,3, 0,0);
    add(1,0,0, 2, 0,1,0, 2,3, 0,0);
    add(1,0,0, 3, 1,0,1, 2,3, 0,0);
    add(1,0,1, 7, 1,0,0, 2,3, 0,1);               // goal on last level -> WIN
    add(1,1,1, 7, 1,0,0, 2,3, 0,1);
    add(0,0,0, 0, 0,0,0, 0,3, 0,0);               // start -> RESET
    add(1,0,0, 1, 1,0,0, 0,3, 0,0);

    // Reset state, held across edges
    #12;
    check("reset_async", 0, 0,0,0, 0,3, 0,0);
    @(posedge clk); #1;
    check("reset_held", 0, 0,0,0, 0,3, 0,0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].s, vq[i].c, vq[i].g);
      check($sformatf("vec%0d", i), vq[i].st, vq[i].clr, vq[i].ld, vq[i].pl,
            vq[i].lvl, vq[i].liv, vq[i].go, vq[i].wn);
    end

    // Reset asserted in the second DIE pause cycle
    step(0,0,0);
    check("mid_load", 2, 0,1,0, 0,3, 0,0);
    step(1,0,0);
    step(1,1,0);
    check("mid_die1", 4, 1,0,0, 0,2, 0,0);
    step(1,0,0);
    check("mid_die2", 4, 1,0,0, 0,2, 0,0);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_async", 0, 0,0,0, 0,3, 0,0);
    @(posedge clk); #1;
    check("mid_rst_held", 0, 0,0,0, 0,3, 0,0);
    rst_n = 1'b1;
    step(1,0,0);
    check("post_rst_start", 1, 1,0,0, 0,3, 0,0);
    for (int i = 0; i < 3; i++) begin
      step(1,0,1);
      check($sformatf("post_rst_wait%0d", i), 1, 1,0,0, 0,3, 0,0);
    end
    step(0,0,0);
    check("post_rst_load", 2, 0,1,0, 0,3, 0,0);
    step(1,0,0);
    check("post_rst_play", 3, 1,0,1, 0,3, 0,0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_statemachine_levels.md
Name: sc_statemachine_levels

Overview:
Parametrised general game controller for Frogger; the successor to the two-state reset/start controller. It sequences start, level load, play, life loss, level advance, game over and win. It owns the level and lives counters and a post-event pause timer. It sits above the lane/frog datapath and drives its clear, load and play-enable controls from collision and goal flags supplied by the comparators.

Parameters:
NUM_LEVELS, 4, number of levels; goal on level NUM_LEVELS-1 means win (>=1)
NUM_LIVES, 3, lives at game start (>=1)
PAUSE_CYCLES, 50000000, clocks held in DIE/LEVELUP before reload (>=1)
LEVEL_W, $clog2(NUM_LEVELS) min 1, level bus width (derived)
LIVES_W, $clog2(NUM_LIVES+1), lives bus width (derived)

Ports:
SC_STATEMACHINELEVELS_CLOCK_50  in  1  system clock, 50 MHz
SC_STATEMACHINELEVELS_RESET_InLow  in  1  asynchronous active-low reset
SC_STATEMACHINELEVELS_startButton_InLow  in  1  start key, active low, already synchronised
SC_STATEMACHINELEVELS_collision_InHigh  in  1  frog hit a hazard, sampled only in PLAY
SC_STATEMACHINELEVELS_goal_InHigh  in  1  frog reached the top row, sampled only in PLAY
SC_STATEMACHINELEVELS_clear_OutLow  out  1  datapath clear, active low
SC_STATEMACHINELEVELS_load_OutHigh  out  1  one-cycle pulse to load the level pattern
SC_STATEMACHINELEVELS_play_OutHigh  out  1  datapath motion enable
SC_STATEMACHINELEVELS_level_Out  out  LEVEL_W  current level, 0-based
SC_STATEMACHINELEVELS_lives_Out  out  LIVES_W  remaining lives
SC_STATEMACHINELEVELS_gameOver_OutHigh  out  1  high while in GAMEOVER
SC_STATEMACHINELEVELS_win_OutHigh  out  1  high while in WIN
SC_STATEMACHINELEVELS_state_Out  out  4  current state code, for debug/display

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset forces state RESET, level=0, lives=NUM_LIVES, pause counter=0, start-edge history=1.
- Output values in RESET: clear=0, load=0, play=0, gameOver=0, win=0.
- State codes: RESET=0, START=1, LOAD=2, PLAY=3, DIE=4, LEVELUP=5, GAMEOVER=6, WIN=7. Codes 8-15 are illegal and go to RESET.
- Start event: a falling edge of startButton_InLow (previous sample=1, current=0). A held button produces exactly one event.
- Outputs are Moore (combinational from state). The counters are registered.
- RESET: next state START unconditionally. Level and lives reinitialise on this cycle.
- START: clear=1. Waits for a start event, then goes to LOAD.
- LOAD: exactly one cycle. load=1 and clear=0, which resets the frog position. Next state PLAY.
- PLAY: play=1, clear=1.
  - collision=1 -> DIE, and lives decrements on the transition edge.
  - else goal=1 and level==NUM_LEVELS-1 -> WIN; level is not changed.
  - else goal=1 -> LEVELUP, and level increments on the transition edge.
  - Collision and goal in the same cycle: collision wins.
- DIE and LEVELUP: play=0, clear=1.
  - Pause counter clears on entry and counts 1..PAUSE_CYCLES; the state exits on the cycle the count equals PAUSE_CYCLES.
  - Residency is PAUSE_CYCLES cycles.
  - DIE exits to GAMEOVER if lives==0, otherwise to LOAD. LEVELUP exits to LOAD.
- GAMEOVER / WIN: play=0, clear=1, gameOver=1 or win=1 respectively. Level and lives hold. A start event goes to RESET (full restart).
- Inputs ignored outside their states:
  - collision and goal are ignored outside PLAY.
  - Start events are ignored outside START, GAMEOVER and WIN.
- Counter bounds: lives never underflows, since decrement occurs only from PLAY with lives>=1. Level never exceeds NUM_LEVELS-1.
- Reset mid-operation (any state, including mid-pause) returns all registers to reset values immediately and asynchronously.
- Latency: collision or goal to play=0 is 1 clock.

Decomposition:
- Package sc_statemachine_pkg: state code localparams (4-bit) and the width helper for derived widths.
- Sub-module sc_edge_detect_falling: 1-bit registered falling-edge detector with async active-low reset and history reset to 1; used for the start button.
- The FSM keeps its conventional structure: next-state block, state register, Moore output block, plus counter registers.

Test Plan (NUM_LEVELS=3, NUM_LIVES=3, PAUSE_CYCLES=4):
1. Release reset, then press start (held 10 cycles) -> RESET->START, then one LOAD cycle with load=1 and clear=0, then PLAY; exactly one load pulse; level=0, lives=3.
2. In PLAY assert collision for 1 cycle -> next cycle DIE, play=0, lives=2; after 4 cycles LOAD, then PLAY.
3. Three collisions total -> lives reaches 0, DIE lasts 4 cycles, then GAMEOVER with gameOver=1; a start event then gives RESET, lives=3, level=0.
4. Goal on levels 0 and 1 -> LEVELUP each time with level 1 then 2; goal on level 2 -> WIN with win=1 and level still 2.
5. Collision and goal asserted in the same PLAY cycle -> DIE, lives decrements, level unchanged.
6. Assert reset low during cycle 2 of the DIE pause -> state=0 and outputs at reset values while reset is low; after release, START again with lives=3 and a start event required.
